// File: rtl/trig_pkg.sv
// -----------------------------------------------------------------------------
// trig_pkg -- shared definitions for the trig_scheduler codebase slice.
//
// Contents:
//   ST_*     : scheduler FSM state encodings (IDLE, REDUCE, SIN, COS, RESP)
//   DEG_*    : angle constants in degrees, `INT_BITS signed
//   cos_arg  : maps a reduced angle a in (-180,180] to the sine argument
//              that yields cos(a), i.e. 90 - a wrapped back into [-180,180]
//
// `INT_BITS / `FLOAT_BITS normally come from constants.h; the guarded
// defaults below (16 / 16) are only used when that header is absent.
// sin_deg results are Q1.14 fixed point, so `FLOAT_BITS must be >= 16.
//
// Optional feature macro used elsewhere in the slice: TRIG_SCHED_CACHE_EN.
// -----------------------------------------------------------------------------
`ifndef INT_BITS
`define INT_BITS 16
`endif
`ifndef FLOAT_BITS
`define FLOAT_BITS 16
`endif

package trig_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_REDUCE = 3'd1;
    localparam state_t ST_SIN    = 3'd2;
    localparam state_t ST_COS    = 3'd3;
    localparam state_t ST_RESP   = 3'd4;

    localparam logic signed [`INT_BITS-1:0] DEG_90  = `INT_BITS'sd90;
    localparam logic signed [`INT_BITS-1:0] DEG_180 = `INT_BITS'sd180;
    localparam logic signed [`INT_BITS-1:0] DEG_360 = `INT_BITS'sd360;

    // cos(a) = sin(90 - a); for a in (-180,180] the raw value lies in
    // [-90,270), so a single -360 correction keeps it in [-180,180].
    function automatic logic signed [`INT_BITS-1:0] cos_arg(
        input logic signed [`INT_BITS-1:0] ang
    );
        logic signed [`INT_BITS-1:0] c;
        c = DEG_90 - ang;
        if (c > DEG_180) begin
            c = c - DEG_360;
        end else begin
            c = c;
        end
        return c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter -- combinational round-robin arbiter.
//
// Scans requesters starting at ptr, wrapping modulo N_REQ; the first active
// request wins.
//
// Ports:
//   req   : in  N_REQ  request vector
//   ptr   : in  ID_W   highest-priority index for this decision
//   grant : out N_REQ  one-hot grant (all zero when no request)
//   idx   : out ID_W   index of the granted requester (0 when none)
//   any   : out 1      at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    // Rotating priority scan; the first hit after ptr locks the result.
    always_comb begin
        int cand_v;
        grant  = {N_REQ{1'b0}};
        idx    = {ID_W{1'b0}};
        any    = 1'b0;
        cand_v = 0;
        for (int off = 0; off < N_REQ; off++) begin
            cand_v = int'(ptr) + off;
            if (cand_v >= N_REQ) begin
                cand_v = cand_v - N_REQ;
            end else begin
                cand_v = cand_v;
            end
            if (!any && req[cand_v]) begin
                any           = 1'b1;
                idx           = ID_W'(cand_v);
                grant[cand_v] = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/sin_deg.sv
// -----------------------------------------------------------------------------
// sin_deg -- purely combinational sine of an integer degree angle.
//
// Uses Bhaskara I's rational approximation on the magnitude m in [0,180]:
//     sin(m) ~= 4*m*(180-m) / (40500 - m*(180-m))
// scaled to Q1.14 (16384 = 1.0) and truncated toward zero; the sign of the
// input is reapplied afterwards (sin is odd).  Exact at 0, 30, 90, 150, 180.
//
// Ports:
//   angle : in  `INT_BITS signed, must lie in [-180,180]
//   value : out `FLOAT_BITS signed, Q1.14 sine of angle
// -----------------------------------------------------------------------------
`ifndef INT_BITS
`define INT_BITS 16
`endif
`ifndef FLOAT_BITS
`define FLOAT_BITS 16
`endif

module sin_deg (
    input  logic signed [`INT_BITS-1:0]   angle,
    output logic signed [`FLOAT_BITS-1:0] value
);

    logic signed [`INT_BITS-1:0] abs_s;
    logic [8:0]                  mag_s;
    logic [31:0]                 prod_s;
    logic [31:0]                 num_s;
    logic [31:0]                 den_s;
    logic [31:0]                 quo_s;

    // Magnitude-based rational approximation, sign restored at the end.
    always_comb begin
        if (angle < `INT_BITS'sd0) begin
            abs_s = -angle;
        end else begin
            abs_s = angle;
        end
        mag_s  = 9'(abs_s);
        prod_s = 32'(mag_s) * (32'd180 - 32'(mag_s));
        // 4 * 16384 = 2^16, so the Q1.14 numerator is a plain shift.
        num_s  = prod_s << 5'd16;
        den_s  = 32'd40500 - prod_s;
        quo_s  = num_s / den_s;
        if (angle < `INT_BITS'sd0) begin
            value = -(`FLOAT_BITS'(quo_s));
        end else begin
            value = `FLOAT_BITS'(quo_s);
        end
    end

endmodule

// File: rtl/trig_scheduler.sv
// -----------------------------------------------------------------------------
// trig_scheduler -- shared sin/cos service for N_REQ requesters.
//
// A request's degree angle is reduced to (-180,180] by +/-360 steps (one per
// cycle), then sin and cos are evaluated back to back through a single
// sin_deg instance and returned on one response channel tagged with the
// requester id.  Requesters are served round-robin.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : in  N_REQ            per-requester request valid
//   req_angle   : in  N_REQ*`INT_BITS  packed signed angles, slice i*`INT_BITS
//   req_ready   : out N_REQ            one-hot accept, only in IDLE
//   resp_valid  : out 1                response valid (held until resp_ready)
//   resp_ready  : in  1                response consumer ready
//   resp_id     : out ID_W             requester index of the response
//   resp_sin    : out `FLOAT_BITS      Q1.14 sin(angle)
//   resp_cos    : out `FLOAT_BITS      Q1.14 cos(angle)
//
// Build option: TRIG_SCHED_CACHE_EN adds a one-entry {raw angle, sin, cos}
// cache; a matching request jumps straight from IDLE to RESP.
// -----------------------------------------------------------------------------
`ifndef INT_BITS
`define INT_BITS 16
`endif
`ifndef FLOAT_BITS
`define FLOAT_BITS 16
`endif

module trig_scheduler
    import trig_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ*`INT_BITS-1:0]     req_angle,
    output logic [N_REQ-1:0]               req_ready,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [ID_W-1:0]                resp_id,
    output logic signed [`FLOAT_BITS-1:0]  resp_sin,
    output logic signed [`FLOAT_BITS-1:0]  resp_cos
);

    state_t                         state_r;
    logic [ID_W-1:0]                ptr_r;
    logic [ID_W-1:0]                id_r;
    logic signed [`INT_BITS-1:0]    ang_r;
    logic signed [`INT_BITS-1:0]    cang_r;
    logic signed [`FLOAT_BITS-1:0]  sin_r;
    logic signed [`FLOAT_BITS-1:0]  cos_r;
    logic                           resp_valid_r;

    logic [N_REQ-1:0]               grant_s;
    logic [ID_W-1:0]                gidx_s;
    logic                           gany_s;
    logic [ID_W-1:0]                ptr_nxt_s;
    logic signed [`INT_BITS-1:0]    angle_sel_s;
    logic signed [`INT_BITS-1:0]    sin_in_s;
    logic signed [`FLOAT_BITS-1:0]  sin_out_s;
    logic                           cache_hit_s;
    logic signed [`FLOAT_BITS-1:0]  hit_sin_s;
    logic signed [`FLOAT_BITS-1:0]  hit_cos_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (gidx_s),
        .any   (gany_s)
    );

    // Granted requester's raw angle and the pointer value that follows it.
    always_comb begin
        angle_sel_s = req_angle[int'(gidx_s)*`INT_BITS +: `INT_BITS];
        if (int'(gidx_s) == N_REQ - 1) begin
            ptr_nxt_s = {ID_W{1'b0}};
        end else begin
            ptr_nxt_s = gidx_s + ID_W'(1);
        end
    end

    // Accept is offered only while idle; the arbiter result is one-hot.
    always_comb begin
        if (state_r == ST_IDLE) begin
            req_ready = grant_s;
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
    end

    // sin_deg sees only registered angles: cang_r during COS, ang_r otherwise.
    always_comb begin
        if (state_r == ST_COS) begin
            sin_in_s = cang_r;
        end else begin
            sin_in_s = ang_r;
        end
    end

    sin_deg u_sin (
        .angle (sin_in_s),
        .value (sin_out_s)
    );

`ifdef TRIG_SCHED_CACHE_EN
    logic                           cache_valid_r;
    logic signed [`INT_BITS-1:0]    raw_r;
    logic signed [`INT_BITS-1:0]    cache_ang_r;
    logic signed [`FLOAT_BITS-1:0]  cache_sin_r;
    logic signed [`FLOAT_BITS-1:0]  cache_cos_r;

    // Hit compares against the unreduced angle, so 30 and 390 are distinct.
    always_comb begin
        cache_hit_s = cache_valid_r && (cache_ang_r == angle_sel_s);
        hit_sin_s   = cache_sin_r;
        hit_cos_s   = cache_cos_r;
    end

    // Capture raw angle at grant; refresh the cache with every computed result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_r         <= `INT_BITS'sd0;
            cache_valid_r <= 1'b0;
            cache_ang_r   <= `INT_BITS'sd0;
            cache_sin_r   <= `FLOAT_BITS'sd0;
            cache_cos_r   <= `FLOAT_BITS'sd0;
        end else if (state_r == ST_IDLE && gany_s) begin
            raw_r <= angle_sel_s;
        end else if (state_r == ST_COS) begin
            cache_valid_r <= 1'b1;
            cache_ang_r   <= raw_r;
            cache_sin_r   <= sin_r;
            cache_cos_r   <= sin_out_s;
        end else begin
            cache_valid_r <= cache_valid_r;
        end
    end
`else
    // No cache storage: every request takes the full path.
    always_comb begin
        cache_hit_s = 1'b0;
        hit_sin_s   = `FLOAT_BITS'sd0;
        hit_cos_s   = `FLOAT_BITS'sd0;
    end
`endif

    // Scheduler FSM: grant, reduce, sin, cos, hold response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ptr_r        <= {ID_W{1'b0}};
            id_r         <= {ID_W{1'b0}};
            ang_r        <= `INT_BITS'sd0;
            cang_r       <= `INT_BITS'sd0;
            sin_r        <= `FLOAT_BITS'sd0;
            cos_r        <= `FLOAT_BITS'sd0;
            resp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (gany_s) begin
                        id_r  <= gidx_s;
                        ang_r <= angle_sel_s;
                        ptr_r <= ptr_nxt_s;
                        if (cache_hit_s) begin
                            sin_r        <= hit_sin_s;
                            cos_r        <= hit_cos_s;
                            resp_valid_r <= 1'b1;
                            state_r      <= ST_RESP;
                        end else begin
                            state_r <= ST_REDUCE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REDUCE: begin
                    // -180 takes the +360 branch and lands on 180.
                    if (ang_r > DEG_180) begin
                        ang_r <= ang_r - DEG_360;
                    end else if (ang_r <= -DEG_180) begin
                        ang_r <= ang_r + DEG_360;
                    end else begin
                        state_r <= ST_SIN;
                    end
                end
                ST_SIN: begin
                    sin_r   <= sin_out_s;
                    cang_r  <= cos_arg(ang_r);
                    state_r <= ST_COS;
                end
                ST_COS: begin
                    cos_r        <= sin_out_s;
                    resp_valid_r <= 1'b1;
                    state_r      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_id    = id_r;
    assign resp_sin   = sin_r;
    assign resp_cos   = cos_r;

endmodule

// File: doc/trig_scheduler.md
Name: trig_scheduler

Overview:
- Shared sine/cosine service for degree angles.
- Arbitrates N_REQ requesters (vertex-rotation units) onto one sin_deg instance.
- Per request: reduces any 16-bit signed degree angle to (-180,180]. Then evaluates sin and cos sequentially through the single sin_deg. Returns both values on one response channel tagged with the requester id.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- ID_W, $clog2(N_REQ), requester-id width (localparam).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- req_valid  in  N_REQ  per-requester request valid.
- req_angle  in  N_REQ*`INT_BITS  packed signed angles in degrees; requester i at slice [i*`INT_BITS +: `INT_BITS].
- req_ready  out  N_REQ  one-hot grant/accept.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  ID_W  requester index of the response.
- resp_sin  out  `FLOAT_BITS  signed sin(angle).
- resp_cos  out  `FLOAT_BITS  signed cos(angle).

Behaviour:
- Reset values: state IDLE; req_ready all 0; resp_valid 0; resp_id/resp_sin/resp_cos 0; round-robin pointer 0 (requester 0 highest priority).
- Reset mid-operation aborts the in-flight request. No response is issued; the requester must re-issue.
- Handshake rules:
  - Requester holds req_valid high and req_angle stable until req_ready.
  - Transfer happens when req_valid[i] && req_ready[i].
  - Response holds resp_valid and all response fields stable until resp_ready.
- FSM:
  - IDLE: if any req_valid, round-robin pick g, starting at the pointer. req_ready[g]=1 combinationally in this cycle only. Capture angle and id. Pointer becomes (g+1) mod N_REQ. Go to REDUCE. req_ready is 0 in all other states.
  - REDUCE: one step per cycle.
    - ang > 180: ang -= 360.
    - ang <= -180: ang += 360.
    - Otherwise go to SIN.
    - Plain `INT_BITS arithmetic; no overflow is possible over the full input range. -180 maps to 180.
  - SIN: drive sin_deg with ang and register sin_r. Compute cang = 90 - ang; if cang > 180, cang -= 360. Go to COS.
  - COS: drive sin_deg with cang and register cos_r. Go to RESP.
  - RESP: resp_valid=1. On resp_ready go to IDLE. The next grant happens no earlier than the following cycle (one bubble).
- Latency: an in-range angle handshaken in cycle 0 gives resp_valid in cycle 4. Each ±360 reduction step adds 1 cycle.
- Requests arriving while busy simply wait. Fairness: every continuously-valid requester is served within N_REQ grants.
- sin_deg is purely combinational and is driven only by a registered mux (ang/cang). Its input is always within [-180,180].

Optional Feature:
- Macro: TRIG_SCHED_CACHE_EN.
- When defined:
  - Keeps a one-entry cache {valid, raw_angle, sin, cos}, valid cleared on reset.
  - At grant, if the cache is valid and the raw angle matches, go IDLE->RESP directly. resp_valid appears in cycle 1.
  - The cache is updated with every computed result in COS.
- When undefined: no cache storage; all requests take the full path.

Decomposition:
- trig_pkg: state enum (IDLE, REDUCE, SIN, COS, RESP) and angle constants DEG_90, DEG_180, DEG_360 as `INT_BITS signed. `INT_BITS/`FLOAT_BITS stay in constants.h.
- Sub-module rr_arbiter (N_REQ, req vector, pointer -> one-hot grant + index) is natural and separately testable.
- One sin_deg instance.

Test Plan:
- Single request, requester 0, angle 30 -> req_ready in cycle 0; resp_valid in cycle 4; resp_id=0; resp_sin/resp_cos equal a standalone sin_deg at 30 and 60.
- Angle 90 -> resp_sin = sin_deg(90) (one), resp_cos = sin_deg(0) (zero). Angle -180 -> reduced to 180: resp_sin zero, resp_cos = sin_deg(-90) (minus one).
- Angle 400 -> one reduction step, resp_valid in cycle 5, outputs equal those for 40. Angle -32768 -> 91 steps, result equals the -8 result.
- All 4 requesters valid continuously with resp_ready=1 -> grant order 0,1,2,3,0; each resp_id matches; no starvation.
- resp_ready held low 10 cycles -> resp fields stable, no req_ready asserted. rst_n pulsed low during REDUCE -> outputs return to reset values immediately; no response emitted.
- TRIG_SCHED_CACHE_EN defined: angle 45 twice from different requesters -> second response in cycle 1 with identical values; undefined -> second response in cycle 4.
